// File: rtl/har_tnn1_tnndirect.sv
// har_tnn1_tnndirect: sequential ternary NN classifier, one feature (L1) or one hidden neuron (L2) per cycle.
// Define HAR_TNN1_DONE_EN to add the `done` status output.
module har_tnn1_tnndirect #(
  parameter int FEAT_CNT   = 12,
  parameter int HIDDEN_CNT = 40,
  parameter int FEAT_BITS  = 4,
  parameter int CLASS_CNT  = 6,
  parameter logic [HIDDEN_CNT*FEAT_CNT*2-1:0]  W1 = '0,
  parameter logic [CLASS_CNT*HIDDEN_CNT*2-1:0] W2 = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [FEAT_BITS*FEAT_CNT-1:0]  data,
`ifdef HAR_TNN1_DONE_EN
  output logic                           done,
`endif
  output logic [$clog2(CLASS_CNT)-1:0]   prediction
);

  localparam int TOTAL  = FEAT_CNT + HIDDEN_CNT;
  localparam int CNT_W  = $clog2(TOTAL + 1);
  localparam int HACC_W = $clog2(FEAT_CNT * (2**FEAT_BITS - 1) + 1) + 1;
  localparam int CACC_W = $clog2(HIDDEN_CNT + 1) + 1;
  localparam int PRED_W = $clog2(CLASS_CNT);

  logic [CNT_W-1:0]         cnt;
  logic signed [HACC_W-1:0] hacc [HIDDEN_CNT];
  logic signed [CACC_W-1:0] cacc [CLASS_CNT];
  logic                     in_l1;
  logic                     in_l2;
  logic signed [HACC_W-1:0] x_cur;
  logic                     h_cur;
  logic [1:0]               w1_sel [HIDDEN_CNT];
  logic [1:0]               w2_sel [CLASS_CNT];
  logic signed [CACC_W-1:0] best;

  assign in_l1 = cnt < CNT_W'(FEAT_CNT);
  assign in_l2 = !in_l1 && (cnt < CNT_W'(TOTAL));

  // Current feature (zero-extended) and the W1 column it is multiplied by
  always_comb begin
    x_cur = '0;
    for (int i = 0; i < HIDDEN_CNT; i++) w1_sel[i] = 2'b00;
    for (int j = 0; j < FEAT_CNT; j++) begin
      if (cnt == CNT_W'(j)) begin
        x_cur = HACC_W'(data[FEAT_BITS*j +: FEAT_BITS]);
        for (int i = 0; i < HIDDEN_CNT; i++) w1_sel[i] = W1[2*(i*FEAT_CNT+j) +: 2];
      end
    end
  end

  // Current hidden activation (acc >= 0) and the W2 column it feeds
  always_comb begin
    h_cur = 1'b0;
    for (int k = 0; k < CLASS_CNT; k++) w2_sel[k] = 2'b00;
    for (int i = 0; i < HIDDEN_CNT; i++) begin
      if (cnt == CNT_W'(FEAT_CNT + i)) begin
        h_cur = ~hacc[i][HACC_W-1];
        for (int k = 0; k < CLASS_CNT; k++) w2_sel[k] = W2[2*(k*HIDDEN_CNT+i) +: 2];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      for (int i = 0; i < HIDDEN_CNT; i++) hacc[i] <= '0;
      for (int k = 0; k < CLASS_CNT; k++) cacc[k] <= '0;
    end else begin
      if (in_l1) begin
        for (int i = 0; i < HIDDEN_CNT; i++) begin
          case (w1_sel[i])
            2'b01:   hacc[i] <= hacc[i] + x_cur;
            2'b11:   hacc[i] <= hacc[i] - x_cur;
            default: hacc[i] <= hacc[i];
          endcase
        end
      end
      if (in_l2 && h_cur) begin
        for (int k = 0; k < CLASS_CNT; k++) begin
          case (w2_sel[k])
            2'b01:   cacc[k] <= cacc[k] + CACC_W'(1);
            2'b11:   cacc[k] <= cacc[k] - CACC_W'(1);
            default: cacc[k] <= cacc[k];
          endcase
        end
      end
      if (cnt != CNT_W'(TOTAL)) cnt <= cnt + CNT_W'(1);
    end
  end

  // Strict greater-than keeps the lowest index on ties
  always_comb begin
    best       = cacc[0];
    prediction = '0;
    for (int k = 1; k < CLASS_CNT; k++) begin
      if (cacc[k] > best) begin
        best       = cacc[k];
        prediction = PRED_W'(k);
      end
    end
  end

`ifdef HAR_TNN1_DONE_EN
  assign done = (cnt == CNT_W'(TOTAL));
`endif

endmodule

// File: tb/tb_har_tnn1_tnndirect.sv
// Scoreboard bench for har_tnn1_tnndirect: five instances with different weight sets share clk/rst.
// Expected predictions are queued at stimulus time and checked when the 52-edge window completes.
module tb_har_tnn1_tnndirect;

  localparam int TOTAL = 52;

  function automatic logic [959:0] mk_w1_e();
    logic [959:0] w;
    w          = '0;
    w[1:0]     = 2'b01;
    w[11:10]   = 2'b10;
    w[23:22]   = 2'b11;
    return w;
  endfunction

  function automatic logic [479:0] mk_w2_e();
    logic [479:0] w;
    w          = '0;
    w[81:80]   = 2'b01;
    w[161:160] = 2'b11;
    w[163:162] = 2'b01;
    return w;
  endfunction

  localparam logic [79:0]  Z    = 80'd0;
  localparam logic [79:0]  ONES = {40{2'b01}};
  localparam logic [79:0]  NEGS = {40{2'b11}};
  localparam logic [959:0] W1_C = {480{2'b11}};
  localparam logic [959:0] W1_E = mk_w1_e();
  localparam logic [479:0] W2_B = {Z, Z, ONES, Z, Z, Z};
  localparam logic [479:0] W2_C = {Z, NEGS, Z, ONES, Z, Z};
  localparam logic [479:0] W2_D = {ONES, Z, Z, Z, ONES, Z};
  localparam logic [479:0] W2_E = mk_w2_e();

  localparam logic [47:0] ZERO  = 48'd0;
  localparam logic [47:0] ALL_F = {12{4'hF}};
  localparam logic [47:0] ALL_1 = {12{4'h1}};

  logic        clk = 1'b0;
  logic        rst;
  logic [47:0] data_a, data_b, data_c, data_d, data_e;
  logic [2:0]  pred_a, pred_b, pred_c, pred_d, pred_e;
`ifdef HAR_TNN1_DONE_EN
  logic        done_a, done_b, done_c, done_d, done_e;
`endif

  always #5 clk = ~clk;

  har_tnn1_tnndirect dut_a (.clk(clk), .rst(rst), .data(data_a),
`ifdef HAR_TNN1_DONE_EN
    .done(done_a),
`endif
    .prediction(pred_a));

  har_tnn1_tnndirect #(.W2(W2_B)) dut_b (.clk(clk), .rst(rst), .data(data_b),
`ifdef HAR_TNN1_DONE_EN
    .done(done_b),
`endif
    .prediction(pred_b));

  har_tnn1_tnndirect #(.W1(W1_C), .W2(W2_C)) dut_c (.clk(clk), .rst(rst), .data(data_c),
`ifdef HAR_TNN1_DONE_EN
    .done(done_c),
`endif
    .prediction(pred_c));

  har_tnn1_tnndirect #(.W2(W2_D)) dut_d (.clk(clk), .rst(rst), .data(data_d),
`ifdef HAR_TNN1_DONE_EN
    .done(done_d),
`endif
    .prediction(pred_d));

  har_tnn1_tnndirect #(.W1(W1_E), .W2(W2_E)) dut_e (.clk(clk), .rst(rst), .data(data_e),
`ifdef HAR_TNN1_DONE_EN
    .done(done_e),
`endif
    .prediction(pred_e));

  typedef struct {
    int         unit;
    logic [2:0] exp;
    string      tag;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   edge_cnt;

  function automatic logic [2:0] get_pred(input int u);
    case (u)
      0:       return pred_a;
      1:       return pred_b;
      2:       return pred_c;
      3:       return pred_d;
      default: return pred_e;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0d want=%0d", tag, act, exp);
    end
  endtask

  task automatic pushExp(input int u, input logic [2:0] ex, input string tag);
    exp_t e;
    e.unit = u;
    e.exp  = ex;
    e.tag  = tag;
    sb_q.push_back(e);
  endtask

  // Holds reset, loads data, checks the cleared state and queues the expected results
  task automatic applyStimulus(input logic [47:0] da, db, dc, dd, de,
                               input logic [2:0] ea, eb, ec, ed, ee, input string tag);
    rst    = 1'b0;
    data_a = da; data_b = db; data_c = dc; data_d = dd; data_e = de;
    #1;
    for (int u = 0; u < 5; u++) checkOutput({tag, "_rst_pred"}, get_pred(u), 8'd0);
`ifdef HAR_TNN1_DONE_EN
    checkOutput({tag, "_rst_done"}, done_e, 8'd0);
`endif
    pushExp(0, ea, {tag, "_a"});
    pushExp(1, eb, {tag, "_b"});
    pushExp(2, ec, {tag, "_c"});
    pushExp(3, ed, {tag, "_d"});
    pushExp(4, ee, {tag, "_e"});
  endtask

  task automatic releaseReset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic waitEdges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) edge_cnt <= 0;
    else      edge_cnt <= edge_cnt + 1;
  end

  // Monitor: the result is presented once the fixed window has elapsed
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && edge_cnt == TOTAL) begin
        while (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          checkOutput(e.tag, get_pred(e.unit), e.exp);
        end
      end
    end
  end

  initial begin
    rst = 1'b0;
    data_a = ZERO; data_b = ZERO; data_c = ZERO; data_d = ZERO; data_e = ZERO;
    #2;

    applyStimulus(ALL_F, ALL_F, ALL_F, ALL_F, ALL_F, 3'd0, 3'd3, 3'd0, 3'd1, 3'd1, "ones");
    releaseReset();
    waitEdges(TOTAL - 1);
`ifdef HAR_TNN1_DONE_EN
    checkOutput("done_edge51", done_e, 8'd0);
`endif
    waitEdges(1);
`ifdef HAR_TNN1_DONE_EN
    checkOutput("done_edge52", done_e, 8'd1);
`endif
    waitEdges(3);

    applyStimulus(ZERO, ZERO, ZERO, ZERO, ZERO, 3'd0, 3'd3, 3'd2, 3'd1, 3'd1, "zeros");
    releaseReset();
    waitEdges(TOTAL + 2);

    applyStimulus(ALL_1, ALL_1, ALL_1, ALL_1, ALL_1, 3'd0, 3'd3, 3'd0, 3'd1, 3'd1, "ones1");
    releaseReset();
    waitEdges(TOTAL + 2);

    applyStimulus(ZERO, ZERO, 48'h000000000001, ZERO, 48'h400000F00003,
                  3'd0, 3'd3, 3'd0, 3'd1, 3'd2, "neg1");
    releaseReset();
    waitEdges(TOTAL + 2);

    applyStimulus(ZERO, ZERO, ZERO, ZERO, 48'hF00000000000, 3'd0, 3'd3, 3'd2, 3'd1, 3'd2, "hi_feat");
    releaseReset();
    waitEdges(TOTAL + 2);

    applyStimulus(ZERO, ZERO, 48'hF00000000000, ZERO, 48'h500000000005,
                  3'd0, 3'd3, 3'd0, 3'd1, 3'd1, "balance");
    releaseReset();
    waitEdges(TOTAL + 2);

    // Data change after two features consumed: only features 2..11 see the new value
    applyStimulus(ZERO, ZERO, ZERO, ZERO, 48'h000000000003, 3'd0, 3'd3, 3'd0, 3'd1, 3'd2, "mid_l1");
    releaseReset();
    waitEdges(2);
    data_c = ALL_F;
    data_e = 48'h40000000000F;
    waitEdges(TOTAL - 2 + 2);

    // Data change during L2 and after done must be ignored
    applyStimulus(ZERO, ZERO, ZERO, ZERO, 48'h00000000000F, 3'd0, 3'd3, 3'd2, 3'd1, 3'd1, "l2_ign");
    releaseReset();
    waitEdges(20);
    data_c = ALL_F;
    data_e = 48'hF00000000000;
    waitEdges(TOTAL - 20 + 1);
    data_c = ALL_1;
    waitEdges(70);
    checkOutput("hold_c", pred_c, 8'd2);
    checkOutput("hold_e", pred_e, 8'd1);
    checkOutput("hold_b", pred_b, 8'd3);
`ifdef HAR_TNN1_DONE_EN
    checkOutput("hold_done", done_e, 8'd1);
`endif

    // Reset at edge 20 aborts the run; the restart uses new data for dut_c
    rst = 1'b0;
    data_a = ZERO; data_b = ZERO; data_c = ZERO; data_d = ZERO; data_e = ZERO;
    #1;
    releaseReset();
    waitEdges(20);
    applyStimulus(ZERO, ZERO, ALL_1, ZERO, ZERO, 3'd0, 3'd3, 3'd0, 3'd1, 3'd1, "midrst");
    @(posedge clk);
    releaseReset();
    waitEdges(TOTAL + 2);

    while (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      total++;
      bad++;
      $display("[TB] FAIL %s never checked want=%0d", e.tag, e.exp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
